// File: rtl/i2c_pkg.sv
// Shared types and quarter-level tables for the I2C byte engine.
package i2c_pkg;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_STOP  = 2'd1,
        CMD_WRITE = 2'd2,
        CMD_READ  = 2'd3
    } i2c_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_STOP,
        ST_WRITE,
        ST_READ
    } i2c_eng_state_t;

    // Bit n holds the level for quarter qn.
    localparam logic [3:0] START_SCL = 4'b0111;
    localparam logic [3:0] START_SDA = 4'b0011;
    localparam logic [3:0] STOP_SCL  = 4'b1110;
    localparam logic [3:0] STOP_SDA  = 4'b1100;

    function automatic i2c_eng_state_t cmd2state(input i2c_cmd_t c);
        case (c)
            CMD_START: return ST_START;
            CMD_STOP:  return ST_STOP;
            CMD_WRITE: return ST_WRITE;
            default:   return ST_READ;
        endcase
    endfunction

endpackage

// File: rtl/i2c_byte_engine_if.sv
// Command/response port between the register block (master) and the byte engine (slave).
interface i2c_byte_engine_if;
    import i2c_pkg::*;

    logic       cmd_valid;
    logic       cmd_ready;
    i2c_cmd_t   cmd;
    logic [7:0] cmd_data;
    logic       cmd_ack_out;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_nack;
    logic       busy;

    modport master (
        output cmd_valid, cmd, cmd_data, cmd_ack_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_nack, busy
    );

    modport slave (
        input  cmd_valid, cmd, cmd_data, cmd_ack_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_nack, busy
    );

endinterface

// File: rtl/i2c_byte_engine_quarter_tick.sv
// SCL quarter-period prescaler: one-cycle tick on the last cycle of every quarter.
module i2c_quarter_tick #(
    parameter int unsigned DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic run_i,
    input  logic hold_i,
    output logic tick_o
);
    localparam logic [15:0] LAST = 16'(DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    assign tick_o = run_i && !hold_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i)
            cnt_d = '0;
        else if (run_i && !hold_i)
            cnt_d = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/i2c_byte_engine.sv
// I2C master byte engine: START/STOP/WRITE/READ commands, open-drain SDA, quarter-based SCL.
// Optional slave clock stretching is enabled with `define I2C_CLK_STRETCH_EN.
module i2c_byte_engine
    import i2c_pkg::*;
#(
    parameter int unsigned DIV = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    i2c_byte_engine_if.slave        bus,
    input  logic                    sda_i,
    input  logic                    scl_i,
    output logic                    sda_o,
    output logic                    sda_o_en,
    output logic                    scl_o
);
    i2c_eng_state_t state_q, state_d;
    logic [1:0] qtr_q, qtr_d;
    logic [3:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic       ack_q, ack_d;
    logic       scl_q, scl_d, sda_q, sda_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       rsp_nack_q, rsp_nack_d;
    logic       accept, tick, hold, is_data, last;

    assign accept = bus.cmd_valid && (state_q == ST_IDLE);

`ifdef I2C_CLK_STRETCH_EN
    assign hold = scl_q && !scl_i;
`else
    // Stretching disabled: scl_i has no effect on timing.
    assign hold = 1'b0 & scl_i;
`endif

    i2c_quarter_tick #(.DIV(DIV)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .restart_i(accept),
        .run_i    (state_q != ST_IDLE),
        .hold_i   (hold),
        .tick_o   (tick)
    );

    assign is_data = (state_q == ST_WRITE) || (state_q == ST_READ);
    assign last    = (qtr_q == 2'd3) && (!is_data || bit_q == 4'd8);

    always_comb begin
        state_d     = state_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        ack_d       = ack_q;
        scl_d       = scl_q;
        sda_d       = sda_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_nack_d  = rsp_nack_q;
        if (accept) begin
            state_d    = cmd2state(bus.cmd);
            qtr_d      = 2'd0;
            bit_d      = 4'd0;
            ack_d      = bus.cmd_ack_out;
            rsp_data_d = 8'd0;
            rsp_nack_d = 1'b0;
            // READ keeps tx all-ones so its data bits release SDA.
            tx_d       = (bus.cmd == CMD_WRITE) ? bus.cmd_data : 8'hFF;
            case (bus.cmd)
                CMD_START: begin scl_d = START_SCL[0]; sda_d = START_SDA[0]; end
                CMD_STOP:  begin scl_d = STOP_SCL[0];  sda_d = STOP_SDA[0];  end
                default:   begin scl_d = 1'b0;         sda_d = tx_d[7];      end
            endcase
        end else if (tick) begin
            if (is_data && qtr_q == 2'd2) begin
                if (bit_q == 4'd8) begin
                    if (state_q == ST_WRITE) rsp_nack_d = sda_i;
                end else if (state_q == ST_READ) begin
                    rsp_data_d = {rsp_data_q[6:0], sda_i};
                end
            end
            if (last) begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b1;
            end else begin
                qtr_d = qtr_q + 2'd1;
                if (qtr_q == 2'd3) begin
                    bit_d = bit_q + 4'd1;
                    tx_d  = {tx_q[6:0], 1'b1};
                end
                case (state_q)
                    ST_START: begin scl_d = START_SCL[qtr_d]; sda_d = START_SDA[qtr_d]; end
                    ST_STOP:  begin scl_d = STOP_SCL[qtr_d];  sda_d = STOP_SDA[qtr_d];  end
                    default: begin
                        scl_d = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                        sda_d = (state_q == ST_READ && bit_d == 4'd8) ? ack_q : tx_d[7];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            qtr_q       <= 2'd0;
            bit_q       <= 4'd0;
            tx_q        <= 8'd0;
            ack_q       <= 1'b0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            rsp_nack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            ack_q       <= ack_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_nack_q  <= rsp_nack_d;
        end
    end

    assign bus.cmd_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_nack  = rsp_nack_q;
    assign scl_o         = scl_q;
    assign sda_o         = sda_q;
    assign sda_o_en      = ~sda_q;

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Directed bench for i2c_byte_engine at DIV=4 with a wired-AND model of SDA/SCL.
module tb_i2c_byte_engine;
    import i2c_pkg::*;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic slave_bit = 1'b1;
    logic scl_pull = 1'b0;
    logic sda_o, sda_o_en, scl_o;
    logic sda_line, scl_line;
    int   total = 0;
    int   bad = 0;

    i2c_byte_engine_if bus();

    assign sda_line = ~sda_o_en & slave_bit;
    assign scl_line = scl_o & ~scl_pull;

    i2c_byte_engine #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .sda_i   (sda_line),
        .scl_i   (scl_line),
        .sda_o   (sda_o),
        .sda_o_en(sda_o_en),
        .scl_o   (scl_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Offers one command; returns 1 ns after the accepting edge.
    task automatic issue(input i2c_cmd_t c, input logic [7:0] d, input logic a);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 200) begin step(); n++; end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL issue_ready: cmd_ready=%b required 1 within 200 cycles", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1; bus.cmd = c; bus.cmd_data = d; bus.cmd_ack_out = a;
        step();
        bus.cmd_valid = 1'b0; bus.cmd_data = 8'h00; bus.cmd_ack_out = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++;
        if ({scl_o, sda_o, sda_o_en, bus.cmd_ready, bus.rsp_valid, bus.rsp_nack, bus.busy} !== 7'b1101000
            || bus.rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL reset: scl=%b sda=%b en=%b rdy=%b rv=%b nack=%b busy=%b data=%h required 1 1 0 1 0 0 0 00",
                     scl_o, sda_o, sda_o_en, bus.cmd_ready, bus.rsp_valid, bus.rsp_nack, bus.busy, bus.rsp_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_start();
        logic [3:0] es = 4'b0111;
        logic [3:0] ed = 4'b0011;
        int errs = 0;
        issue(CMD_START, 8'h00, 1'b0);
        for (int k = 0; k < 16; k++) begin
            if (scl_o !== es[k/4] || sda_o !== ed[k/4] || bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1) begin
                errs++;
                if (errs == 1) $display("FAIL start_pins: k=%0d scl=%b sda=%b rv=%b busy=%b required %b %b 0 1",
                                        k, scl_o, sda_o, bus.rsp_valid, bus.busy, es[k/4], ed[k/4]);
            end
            step();
        end
        total++; if (errs != 0) bad++;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b1) begin
            bad++; $display("FAIL start_rsp: rv=%b rdy=%b required 1 1 at T+17", bus.rsp_valid, bus.cmd_ready);
        end
        step();
        total++;
        if (bus.rsp_valid !== 1'b0 || scl_o !== 1'b0 || sda_o !== 1'b0) begin
            bad++; $display("FAIL start_hold: rv=%b scl=%b sda=%b required 0 0 0", bus.rsp_valid, scl_o, sda_o);
        end
    endtask

    task automatic test_write(input logic [7:0] d, input logic ack_lvl, input logic exp_nack);
        int errs = 0;
        issue(CMD_WRITE, d, 1'b0);
        for (int k = 0; k < 144; k++) begin
            int  i = k / 16;
            int  q = (k / 4) % 4;
            logic xs = (q == 1 || q == 2);
            logic xd = (i < 8) ? d[7-i] : 1'b1;
            slave_bit = (i == 8) ? ack_lvl : 1'b1;
            if (scl_o !== xs || sda_o !== xd || sda_o_en !== ~xd || bus.rsp_valid !== 1'b0) begin
                errs++;
                if (errs == 1) $display("FAIL write_%h_pins: k=%0d scl=%b sda=%b en=%b required %b %b %b",
                                        d, k, scl_o, sda_o, sda_o_en, xs, xd, ~xd);
            end
            step();
        end
        slave_bit = 1'b1;
        total++; if (errs != 0) bad++;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_nack !== exp_nack || bus.rsp_data !== 8'h00) begin
            bad++; $display("FAIL write_%h_rsp: rv=%b nack=%b data=%h required 1 %b 00 at T+145",
                            d, bus.rsp_valid, bus.rsp_nack, bus.rsp_data, exp_nack);
        end
        step();
    endtask

    task automatic test_read(input logic [7:0] sb, input logic ack_out, input logic [7:0] exp_data);
        int errs = 0;
        int en_errs = 0;
        issue(CMD_READ, 8'h00, ack_out);
        for (int k = 0; k < 144; k++) begin
            int  i = k / 16;
            int  q = (k / 4) % 4;
            logic xs = (q == 1 || q == 2);
            logic xd = (i < 8) ? 1'b1 : ack_out;
            slave_bit = (i < 8) ? sb[7-i] : 1'b1;
            if (scl_o !== xs || sda_o !== xd) begin
                errs++;
                if (errs == 1) $display("FAIL read_%h_pins: k=%0d scl=%b sda=%b required %b %b", sb, k, scl_o, sda_o, xs, xd);
            end
            if (i == 8 && sda_o_en !== ~ack_out) begin
                en_errs++;
                if (en_errs == 1) $display("FAIL read_%h_ackslot: k=%0d sda_o_en=%b required %b", sb, k, sda_o_en, ~ack_out);
            end
            step();
        end
        slave_bit = 1'b1;
        total++; if (errs != 0) bad++;
        total++; if (en_errs != 0) bad++;
        total++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_data || bus.rsp_nack !== 1'b0) begin
            bad++; $display("FAIL read_%h_rsp: rv=%b data=%h nack=%b required 1 %h 0",
                            sb, bus.rsp_valid, bus.rsp_data, bus.rsp_nack, exp_data);
        end
        step();
        total++;
        if (bus.rsp_data !== exp_data || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL read_%h_hold: data=%h rv=%b required %h 0", sb, bus.rsp_data, bus.rsp_valid, exp_data);
        end
    endtask

    task automatic test_rst_abort();
        int seen = 0;
        issue(CMD_WRITE, 8'hFF, 1'b0);
        repeat (64) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if (scl_o !== 1'b1 || sda_o_en !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL abort_pins: scl=%b en=%b rdy=%b busy=%b required 1 0 1 0",
                            scl_o, sda_o_en, bus.cmd_ready, bus.busy);
        end
        for (int k = 0; k < 150; k++) begin
            if (bus.rsp_valid !== 1'b0) seen++;
            step();
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL abort_norsp: rsp_valid pulses=%0d required 0", seen); end
    endtask

    task automatic test_back_to_back();
        issue(CMD_START, 8'h00, 1'b0);
        repeat (16) step();
        total++;
        if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_start_rsp: rv=%b required 1", bus.rsp_valid); end
        bus.cmd_valid = 1'b1; bus.cmd = CMD_STOP;
        step();
        bus.cmd_valid = 1'b0;
        total++;
        if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0 || scl_o !== 1'b0 || sda_o !== 1'b0) begin
            bad++; $display("FAIL b2b_stop_q0: busy=%b rdy=%b scl=%b sda=%b required 1 0 0 0",
                            bus.busy, bus.cmd_ready, scl_o, sda_o);
        end
        repeat (DIV) step();
        total++;
        if (scl_o !== 1'b1 || sda_o !== 1'b0) begin
            bad++; $display("FAIL b2b_stop_q1: scl=%b sda=%b required 1 0", scl_o, sda_o);
        end
        repeat (2*DIV) step();
        total++;
        if (scl_o !== 1'b1 || sda_o !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_stop_q3: scl=%b sda=%b rv=%b required 1 1 0", scl_o, sda_o, bus.rsp_valid);
        end
        repeat (DIV) step();
        total++;
        if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL b2b_stop_rsp: rv=%b required 1 at T+17", bus.rsp_valid); end
        step();
    endtask

`ifdef I2C_CLK_STRETCH_EN
    task automatic test_stretch();
        issue(CMD_START, 8'h00, 1'b0);
        repeat (DIV) step();
        scl_pull = 1'b1;
        repeat (10) step();
        scl_pull = 1'b0;
        repeat (16 - DIV - 1) step();
        total++;
        if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL stretch_early: rv=%b required 0 at T+26", bus.rsp_valid); end
        step();
        total++;
        if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL stretch_rsp: rv=%b required 1 at T+27", bus.rsp_valid); end
        step();
    endtask
`endif

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd = CMD_START; bus.cmd_data = 8'h00; bus.cmd_ack_out = 1'b0;
        test_reset();
        test_start();
        test_write(8'hA5, 1'b0, 1'b0);
        test_write(8'h00, 1'b1, 1'b1);
        test_read(8'h3C, 1'b1, 8'h3C);
        test_read(8'h81, 1'b0, 8'h81);
        test_rst_abort();
        test_back_to_back();
`ifdef I2C_CLK_STRETCH_EN
        test_stretch();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2c_byte_engine.md
# i2c_byte_engine

- Bit/byte-level I2C master engine; sits directly downstream of the Wishbone register block.
- Executes one command at a time (START, STOP, WRITE byte, READ byte) handed over through a valid/ready command port.
- Generates SCL and open-drain SDA from a programmable quarter-period prescaler, samples SDA, and returns one response per command.
- Owns the physical `sda_i`/`sda_o`/`scl_o`/`sda_o_en` pins that the register block previously tied off.

## Interface
- `DIV`, default 250: system clocks per SCL quarter period; legal range 2..65535; SCL frequency = f_clk / (4*DIV).
- `clk` in 1: single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: engine idle and able to accept a command.
- `cmd` in 2: command code from the package enum: START=0, STOP=1, WRITE=2, READ=3.
- `cmd_data` in 8: byte to transmit (WRITE only).
- `cmd_ack_out` in 1: acknowledge bit the master sends after a READ; 0=ACK, 1=NACK.
- `rsp_valid` out 1: one-cycle pulse when a command completes.
- `rsp_data` out 8: received byte (READ); 0 for all other commands.
- `rsp_nack` out 1: SDA sampled in the ACK slot of a WRITE; 0 for all other commands.
- `busy` out 1: high whenever the state is not IDLE.
- `sda_i` in 1: SDA line level.
- `scl_i` in 1: SCL line level; only used with the clock-stretch feature.
- `sda_o` out 1: intended SDA level.
- `sda_o_en` out 1: drive enable; always equals ~`sda_o` (open-drain: the engine drives low only, otherwise releases).
- `scl_o` out 1: SCL level.

## Operation
- Reset values: `scl_o`=1, `sda_o`=1, `sda_o_en`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_nack`=0, `busy`=0; state=IDLE.
- Reset asserted mid-command aborts immediately; no `rsp_valid` is issued for the aborted command.
- A command is accepted only on a cycle where `cmd_valid` && `cmd_ready`. `cmd`, `cmd_data` and `cmd_ack_out` are latched on that cycle and ignored thereafter.
- States: IDLE, START, STOP, WRITE, READ. Every non-IDLE state returns to IDLE when its last quarter ends.
- Every command is a sequence of quarters, each DIV cycles long. Levels listed per quarter q0..q3 as (SCL, SDA):
  - START: (1,1) (1,1) (1,0) (0,0).
  - STOP: (0,0) (1,0) (1,1) (1,1).
  - Data/ack bit: (0,b) (1,b) (1,b) (0,b). SDA is sampled on the last cycle of q2.
- WRITE: 8 data bits, MSB first, with b=`cmd_data` bit. Then an ACK bit with SDA released (b=1); the sampled value goes to `rsp_nack`. 9 bits = 36 quarters.
- READ: 8 bits with SDA released; samples are shifted in MSB first to form `rsp_data`. Then an ACK bit with b=`cmd_ack_out`. 36 quarters.
- Commands are accepted in any order; no protocol legality checking (for example, WRITE without a prior START is executed as-is).

## Timing
- Accept at cycle T.
- q0 levels appear on the pins at T+1.
- Each quarter lasts exactly DIV cycles.
- `rsp_valid` pulses at T+1+N*DIV, where N=4 for START/STOP and N=36 for WRITE/READ. `cmd_ready` returns high in that same cycle.
- `rsp_data`/`rsp_nack` are valid in the `rsp_valid` cycle and hold until the next accept.
- Back-to-back: a command accepted in the `rsp_valid` cycle starts its q0 on the next cycle, with no idle gap.
- Pins hold their last q3 levels while IDLE.
- Bit counter counts 0..8; the quarter counter is 2 bits and wraps q3→q0 between bits.

## Configuration
- `I2C_CLK_STRETCH_EN` defined: while `scl_o`=1 and `scl_i`=0 (slave stretching), the prescaler counter freezes. The current quarter extends by exactly the number of stretched cycles; response latency grows by the same amount.
- Not defined: `scl_i` is ignored and timing is exactly as specified in Timing.

## Structure
- Package `i2c_pkg` holds:
  - `i2c_cmd_t` enum (START/STOP/WRITE/READ).
  - `i2c_eng_state_t` enum.
  - Quarter-level constants for START/STOP.
- Sub-module `i2c_quarter_tick`: DIV prescaler with `hold` input; emits a one-cycle `tick` on the last cycle of each quarter and restarts on command accept.

## Test plan
- DIV=4, START → pins (1,1)(1,1)(1,0)(0,0), 4 cycles each; `rsp_valid` at T+17.
- WRITE 0xA5, bench holds `sda_i`=0 in the ACK slot → SDA during SCL-high is 1,0,1,0,0,1,0,1 then released; `rsp_nack`=0; `rsp_valid` at T+145.
- WRITE 0x00 with `sda_i`=1 in the ACK slot → `rsp_nack`=1.
- READ, slave drives 0x3C, `cmd_ack_out`=1 → `rsp_data`=0x3C, SDA released in the ACK slot.
- READ with `cmd_ack_out`=0 → `sda_o_en`=1 throughout the ACK slot.
- `rst` asserted at the fifth bit of a WRITE → next cycle `scl_o`=1, `sda_o_en`=0, `cmd_ready`=1; no `rsp_valid`.
- Back-to-back START then STOP → STOP q0 begins the cycle after START's `rsp_valid`.
- With `I2C_CLK_STRETCH_EN`, hold `scl_i`=0 for 10 cycles during a q1 → `rsp_valid` delayed by exactly 10 cycles.
